// File: rtl/systolic_host_sequencer_pkg.sv
// Shared constants, header layout and FSM state encoding for the systolic host sequencer.
package systolic_host_sequencer_pkg;

  localparam int MEM_WORDS    = 1024;  // words per matrix memory (4 rows x 256)
  localparam int INST_SLOTS   = 8;     // instruction memory depth, last slot forced to 0
  localparam int RES_PER_INST = 16;    // one 4x4 tile per instruction
  localparam int MAX_INST     = 7;     // largest legal instruction count in a header

  localparam int ADDR_W  = $clog2(MEM_WORDS);
  localparam int INST_AW = $clog2(INST_SLOTS);
  localparam int RES_AW  = 7;          // 112 results max, never wraps

  // Header word layout
  localparam int HDR_N_LSB   = 0;
  localparam int HDR_N_MSB   = 3;
  localparam int HDR_SAME_AB = 4;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_I,
    START,
    WAIT_DONE,
    RD_ADDR,
    RD_WAIT,
    RD_OUT
  } state_e;

endpackage

// File: rtl/systolic_result_drain.sv
// Result readout: walks addrO over all result words, waits out the read latency and
// presents each word on a valid/ready output register held stable under backpressure.
module systolic_result_drain
  import systolic_host_sequencer_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  state_e            state_i,
  input  logic              start_i,
  input  logic [2:0]        n_i,
  output logic [RES_AW-1:0] addr_o,
  input  logic [31:0]       data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [31:0]       m_data_o,
  output logic              m_last_o,
  output state_e            state_next_o
);

  logic [RES_AW-1:0] r_q, r_d;
  logic [7:0]        wait_q, wait_d;
  logic              valid_q, valid_d;
  logic [31:0]       data_q, data_d;
  logic              last_q, last_d;
  logic [RES_AW-1:0] last_idx;

  assign last_idx = RES_AW'(RES_PER_INST * int'(n_i)) - RES_AW'(1);

  // Readout sequencing: result index, latency wait and output register updates
  always_comb begin
    r_d          = r_q;
    wait_d       = wait_q;
    valid_d      = valid_q;
    data_d       = data_q;
    last_d       = last_q;
    state_next_o = state_i;
    if (start_i) begin
      r_d = '0;
    end
    case (state_i)
      RD_ADDR: begin
        wait_d       = '0;
        state_next_o = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_q == 8'(READ_LAT - 1)) begin
          data_d       = data_i;
          valid_d      = 1'b1;
          last_d       = (r_q == last_idx);
          state_next_o = RD_OUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RD_OUT: begin
        if (m_ready_i) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_next_o = IDLE;
          end else begin
            r_d          = r_q + RES_AW'(1);
            state_next_o = RD_ADDR;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Readout registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= '0;
      wait_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      r_q     <= r_d;
      wait_q  <= wait_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign addr_o    = r_q;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/systolic_host_sequencer.sv
// Hardware host for the systolic array: loads matrices and instructions from a word
// stream, starts the array, waits for completion and streams the results out.
module systolic_host_sequencer
  import systolic_host_sequencer_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [15:0]         s_data,
  output logic [ADDR_W-1:0]   addrA,
  output logic [15:0]         dataA,
  output logic                enA,
  output logic [ADDR_W-1:0]   addrB,
  output logic [15:0]         dataB,
  output logic                enB,
  output logic [INST_AW-1:0]  addrI,
  output logic [3:0]          dataI,
  output logic                enI,
  output logic                ap_start,
  input  logic                ap_done,
  output logic [RES_AW-1:0]   addrO,
  input  logic [31:0]         dataO,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [31:0]         m_data,
  output logic                m_last,
  output logic                busy,
  output logic                err
);

  state_e               state_q, state_d, rd_state_next;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [2:0]           n_q, n_d;
  logic                 same_ab_q, same_ab_d;
  logic [ADDR_W-1:0]    addrA_q, addrA_d, addrB_q, addrB_d;
  logic [15:0]          dataA_q, dataA_d, dataB_q, dataB_d;
  logic                 enA_q, enA_d, enB_q, enB_d, enI_q, enI_d;
  logic [INST_AW-1:0]   addrI_q, addrI_d;
  logic [3:0]           dataI_q, dataI_d;
  logic                 err_q, err_d;
  logic [3:0]           hdr_n;
  logic                 hs;
  logic                 last_mem_word;
  logic                 last_inst_word;

  assign s_ready        = (state_q == IDLE) || (state_q == LOAD_A) ||
                          (state_q == LOAD_B) || (state_q == LOAD_I);
  assign hs             = s_valid && s_ready;
  assign hdr_n          = s_data[HDR_N_MSB:HDR_N_LSB];
  assign last_mem_word  = (cnt_q == ADDR_W'(MEM_WORDS - 1));
  assign last_inst_word = (cnt_q == ADDR_W'(INST_SLOTS - 1));

  // Main FSM next state plus registered memory-write ports for the loader
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    same_ab_d = same_ab_q;
    addrA_d   = addrA_q;
    dataA_d   = dataA_q;
    enA_d     = 1'b0;
    addrB_d   = addrB_q;
    dataB_d   = dataB_q;
    enB_d     = 1'b0;
    addrI_d   = addrI_q;
    dataI_d   = dataI_q;
    enI_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (hdr_n == 4'd0 || hdr_n > 4'(MAX_INST)) begin
            err_d = 1'b1;
          end else begin
            n_d       = hdr_n[2:0];
            same_ab_d = s_data[HDR_SAME_AB];
            cnt_d     = '0;
            state_d   = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        if (hs) begin
          enA_d   = 1'b1;
          addrA_d = cnt_q;
          dataA_d = s_data;
          if (same_ab_q) begin
            enB_d   = 1'b1;
            addrB_d = cnt_q;
            dataB_d = s_data;
          end
          if (last_mem_word) begin
            cnt_d   = '0;
            state_d = same_ab_q ? LOAD_I : LOAD_B;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (hs) begin
          enB_d   = 1'b1;
          addrB_d = cnt_q;
          dataB_d = s_data;
          if (last_mem_word) begin
            cnt_d   = '0;
            state_d = LOAD_I;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      LOAD_I: begin
        if (hs) begin
          enI_d   = 1'b1;
          addrI_d = cnt_q[INST_AW-1:0];
          // The terminating slot is always an end-of-program marker.
          dataI_d = last_inst_word ? 4'd0 : s_data[3:0];
          if (last_inst_word) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ap_done) begin
          state_d = RD_ADDR;
        end
      end
      RD_ADDR, RD_WAIT, RD_OUT: begin
        state_d = rd_state_next;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and loader registers; reset aborts any job but leaves memories alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      same_ab_q <= 1'b0;
      addrA_q   <= '0;
      dataA_q   <= '0;
      enA_q     <= 1'b0;
      addrB_q   <= '0;
      dataB_q   <= '0;
      enB_q     <= 1'b0;
      addrI_q   <= '0;
      dataI_q   <= '0;
      enI_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      same_ab_q <= same_ab_d;
      addrA_q   <= addrA_d;
      dataA_q   <= dataA_d;
      enA_q     <= enA_d;
      addrB_q   <= addrB_d;
      dataB_q   <= dataB_d;
      enB_q     <= enB_d;
      addrI_q   <= addrI_d;
      dataI_q   <= dataI_d;
      enI_q     <= enI_d;
      err_q     <= err_d;
    end
  end

  systolic_result_drain #(
    .READ_LAT (READ_LAT)
  ) u_drain (
    .clk          (clk),
    .rst          (rst),
    .state_i      (state_q),
    .start_i      ((state_q == WAIT_DONE) && ap_done),
    .n_i          (n_q),
    .addr_o       (addrO),
    .data_i       (dataO),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data),
    .m_last_o     (m_last),
    .state_next_o (rd_state_next)
  );

  assign addrA    = addrA_q;
  assign dataA    = dataA_q;
  assign enA      = enA_q;
  assign addrB    = addrB_q;
  assign dataB    = dataB_q;
  assign enB      = enB_q;
  assign addrI    = addrI_q;
  assign dataI    = dataI_q;
  assign enI      = enI_q;
  assign err      = err_q;
  assign ap_start = (state_q == START);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_host_sequencer.sv
// Bench for systolic_host_sequencer: random job streams against a job-level model
// (expected write lists and result list) with a mock array on the result port.
module tb_systolic_host_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [9:0]  addrA, addrB;
  logic [15:0] dataA, dataB;
  logic        enA, enB, enI;
  logic [2:0]  addrI;
  logic [3:0]  dataI;
  logic        ap_start;
  logic        ap_done = 1'b0;
  logic [6:0]  addrO;
  logic [31:0] dataO = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        err;

  systolic_host_sequencer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .addrA(addrA), .dataA(dataA), .enA(enA), .addrB(addrB), .dataB(dataB), .enB(enB),
    .addrI(addrI), .dataI(dataI), .enI(enI), .ap_start(ap_start), .ap_done(ap_done),
    .addrO(addrO), .dataO(dataO), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Mock array: results are salt + 3*addr with one cycle read latency, done 20 cycles after start
  logic [31:0] salt = '0;
  int          done_cnt = 0;
  always @(posedge clk) begin
    dataO <= salt + 32'(addrO) * 32'd3;
    if (ap_start) done_cnt <= 20;
    else if (done_cnt > 0) done_cnt <= done_cnt - 1;
    ap_done <= (done_cnt == 1) && !ap_start;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Job model
  logic [15:0] exp_a [1024];
  logic [15:0] exp_b [1024];
  logic [3:0]  exp_i [8];
  int  wa, wb, wi, rcnt, n_res, starts, errs;
  bit  cur_same;
  bit  drv_is_data = 1'b0;
  bit  prev_hs = 1'b0;
  bit  last_hs = 1'b0;
  bit  hold_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  int  rdy_mode = 0;
  int  ph = 0;
  logic [3:0] pat = 4'b1001;

  task automatic monitor();
    last_hs = s_valid && s_ready;
    if (!rst) begin
      prev_hs   = 1'b0;
      hold_prev = 1'b0;
      return;
    end
    if (enA || enB || enI || prev_hs) check("wr_timing", enA | enB | enI, prev_hs);
    prev_hs = s_valid && s_ready && drv_is_data;
    if (enA || enB)
      check("ab_select", {enA, enB}, cur_same ? 2'b11 : (wa < 1024 ? 2'b10 : 2'b01));
    if (enA) begin
      if (wa < 1024) begin
        check("addrA", addrA, wa);
        check("dataA", dataA, exp_a[wa]);
      end else check("enA_extra", 1, 0);
      wa++;
    end
    if (enB) begin
      if (wb < 1024) begin
        check("addrB", addrB, wb);
        check("dataB", dataB, exp_b[wb]);
      end else check("enB_extra", 1, 0);
      wb++;
    end
    if (enI) begin
      if (wi < 8) begin
        check("addrI", addrI, wi);
        check("dataI", dataI, exp_i[wi]);
      end else check("enI_extra", 1, 0);
      wi++;
    end
    if (ap_start) starts++;
    if (err) errs++;
    if (hold_prev) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
      check("hold_last", m_last, prev_last);
    end
    if (m_valid && m_ready) begin
      check("res_data", m_data, salt + 32'(3 * rcnt));
      check("res_last", m_last, rcnt == n_res - 1);
      rcnt++;
    end
    hold_prev = m_valid && !m_ready;
    prev_data = m_data;
    prev_last = m_last;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(1));
      default: begin
        m_ready = pat[ph];
        ph = (ph + 1) % 4;
      end
    endcase
  endtask

  // gap_pct < 0 inserts exactly one idle cycle before each word
  task automatic send_word(input logic [15:0] w, input bit is_data, input int gap_pct);
    int tries;
    if (gap_pct < 0) tick();
    else while ($urandom_range(99) < gap_pct) tick();
    s_valid = 1'b1;
    s_data = w;
    drv_is_data = is_data;
    tries = 0;
    do begin
      tick();
      tries++;
    end while (!last_hs && tries < 50);
    if (!last_hs) check("s_ready_timeout", 0, 1);
    s_valid = 1'b0;
    drv_is_data = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    check("rst_enA", enA, 0);
    check("rst_enB", enB, 0);
    check("rst_addrA", addrA, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_ap_start", ap_start, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic run_job(input int n, input bit same, input int gap, input bit fixed,
                         input int abort_at);
    int t;
    salt = fixed ? 32'd0 : $urandom;
    cur_same = same;
    n_res = 16 * n;
    wa = 0; wb = 0; wi = 0; rcnt = 0; starts = 0; errs = 0;
    for (int k = 0; k < 1024; k++) begin
      exp_a[k] = fixed ? 16'(k - 1) : 16'($urandom);
      exp_b[k] = same ? exp_a[k] : 16'($urandom);
    end
    for (int i = 0; i < 7; i++) exp_i[i] = 4'($urandom);
    if (fixed) begin
      exp_i[0] = 4'd5; exp_i[1] = 4'd4; exp_i[2] = 4'd1; exp_i[3] = 4'd2;
      exp_i[4] = 4'd3; exp_i[5] = 4'd0; exp_i[6] = 4'd0;
    end
    exp_i[7] = 4'd0;
    send_word({11'($urandom), same, 4'(n)}, 1'b0, gap);
    for (int k = 0; k < 1024; k++) begin
      send_word(exp_a[k], 1'b1, gap);
      if (k == abort_at) begin
        reset_pulse();
        return;
      end
    end
    if (!same) for (int k = 0; k < 1024; k++) send_word(exp_b[k], 1'b1, gap);
    for (int i = 0; i < 8; i++)
      send_word(i == 7 ? 16'($urandom_range(1, 65535)) : {12'($urandom), exp_i[i]}, 1'b1, gap);
    check("start_s_ready", s_ready, 0);
    check("start_pulse", ap_start, 1);
    check("start_busy", busy, 1);
    t = 0;
    while (rcnt < n_res && t < 4000) begin
      tick();
      t++;
    end
    if (t >= 4000) check("result_timeout", rcnt, n_res);
    repeat (3) tick();
    check("a_writes", wa, 1024);
    check("b_writes", wb, 1024);
    check("i_writes", wi, 8);
    check("start_count", starts, 1);
    check("result_count", rcnt, n_res);
    check("err_count", errs, 0);
    check("end_busy", busy, 0);
    check("end_s_ready", s_ready, 1);
    check("end_m_valid", m_valid, 0);
    $display("job n=%0d same_ab=%0d gap=%0d results=%0d", n, same, gap, rcnt);
  endtask

  task automatic bad_header(input logic [15:0] h, input int exp_errs);
    send_word(h, 1'b0, 0);
    check("bad_err_pulse", err, 1);
    check("bad_busy", busy, 0);
    check("bad_s_ready", s_ready, 1);
    tick();
    tick();
    check("bad_err_low", err, 0);
    check("bad_err_count", errs, exp_errs);
    check("bad_no_writes", wa + wb + wi, 0);
    $display("bad header %04h err_count=%0d", h, errs);
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    check("reset_s_ready", s_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_en", {enA, enB, enI}, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_ap_start", ap_start, 0);
    check("reset_err", err, 0);
    check("reset_addrO", addrO, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    rdy_mode = 0;
    run_job(5, 1'b1, 0, 1'b1, -1);

    wa = 0; wb = 0; wi = 0; errs = 0;
    bad_header(16'h0010, 1);
    bad_header({11'($urandom), 1'($urandom), 4'd8}, 2);
    bad_header({11'($urandom), 1'($urandom), 4'($urandom_range(9, 15))}, 3);

    rdy_mode = 1;
    run_job(1, 1'b0, -1, 1'b0, -1);

    rdy_mode = 2;
    run_job(1, 1'b1, 0, 1'b0, -1);

    rdy_mode = 1;
    run_job(3, 1'b1, 30, 1'b0, 300);
    run_job(2, 1'b1, 0, 1'b0, -1);

    for (int j = 0; j < 2; j++)
      run_job($urandom_range(1, 7), 1'($urandom_range(1)), 20, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
